// File: rtl/aurras_audio_pkg.sv
// Shared audio-front-end types and defaults for the mic capture path.
package aurras_audio_pkg;

  localparam int unsigned NUM_MICS            = 3;
  localparam int unsigned SAMPLE_WIDTH        = 16;
  localparam int unsigned AUDIO_PERIOD_CYCLES = 2048;

  typedef logic signed [SAMPLE_WIDTH-1:0] sample_t;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } aligner_state_t;

  // Width of a cycle timer that can count up to 'limit' without wrapping.
  function automatic int unsigned timer_width(input int unsigned limit);
    return $clog2(limit) + 1;
  endfunction

endpackage

// File: rtl/mic_channel_hold.sv
// Per-mic capture slot: newest sample, pending flag, last emitted value and
// double-delivery (overrun) detection for one channel of the frame aligner.
module mic_channel_hold #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_emit,
  output logic             o_pending,
  output logic [WIDTH-1:0] o_emit_data,
  output logic             o_overrun
);

  logic [WIDTH-1:0] r_hold;
  logic [WIDTH-1:0] r_last;
  logic             r_pending;

  // A sample arriving on the emit edge goes straight into the frame; otherwise
  // the held sample is used, and a channel that never delivered repeats last.
  assign o_emit_data = i_valid   ? i_data :
                       r_pending ? r_hold : r_last;
  assign o_overrun   = i_valid & r_pending;
  assign o_pending   = r_pending;

  // Capture newest sample, track pending, and remember what was emitted.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_hold    <= '0;
      r_last    <= '0;
      r_pending <= 1'b0;
    end else begin
      if (i_valid) begin
        r_hold <= i_data;
      end
      if (i_emit) begin
        r_pending <= 1'b0;
        r_last    <= o_emit_data;
      end else if (i_valid) begin
        r_pending <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/mic_frame_aligner.sv
// Collects one sample per mic into an aligned frame and emits it with a
// single valid pulse; a timeout substitutes the last value for silent mics.
module mic_frame_aligner
  import aurras_audio_pkg::*;
#(
  parameter int unsigned NUM_MICS       = aurras_audio_pkg::NUM_MICS,
  parameter int unsigned WIDTH          = aurras_audio_pkg::SAMPLE_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES = aurras_audio_pkg::AUDIO_PERIOD_CYCLES
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic [NUM_MICS-1:0]       mic_valid_in,
  input  logic [NUM_MICS*WIDTH-1:0] mic_data_in,
  output logic                      frame_valid_out,
  output logic [NUM_MICS*WIDTH-1:0] frame_data_out,
  output logic [NUM_MICS-1:0]       stale_mask_out,
  output logic                      overrun_out,
  output logic [15:0]               frame_count_out
);

  localparam int unsigned   TW         = timer_width(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  aligner_state_t r_state;
  aligner_state_t w_state_next;
  logic [TW-1:0]  r_timer;
  logic [TW-1:0]  w_timer_next;
  logic           w_emit;

  logic [NUM_MICS-1:0]       w_pending;
  logic [NUM_MICS-1:0]       w_next_pending;
  logic [NUM_MICS-1:0]       w_overrun;
  logic [NUM_MICS*WIDTH-1:0] w_emit_data;

  for (genvar g = 0; g < NUM_MICS; g++) begin : g_ch
    mic_channel_hold #(
      .WIDTH(WIDTH)
    ) u_hold (
      .i_clk      (clk_in),
      .i_rst      (rst_in),
      .i_valid    (mic_valid_in[g]),
      .i_data     (mic_data_in[g*WIDTH +: WIDTH]),
      .i_emit     (w_emit),
      .o_pending  (w_pending[g]),
      .o_emit_data(w_emit_data[g*WIDTH +: WIDTH]),
      .o_overrun  (w_overrun[g])
    );
  end

  assign w_next_pending = w_pending | mic_valid_in;

  // Next-state, timer and emit decision: complete frame or timeout.
  always_comb begin
    w_state_next = r_state;
    w_timer_next = r_timer;
    w_emit       = 1'b0;
    case (r_state)
      IDLE: begin
        if (&w_next_pending) begin
          w_emit = 1'b1;
        end else if (|mic_valid_in) begin
          w_state_next = COLLECT;
          w_timer_next = TW'(1);
        end
      end
      COLLECT: begin
        if ((&w_next_pending) || (r_timer == TIMER_LAST)) begin
          w_emit       = 1'b1;
          w_state_next = IDLE;
          w_timer_next = '0;
        end else begin
          w_timer_next = r_timer + TW'(1);
        end
      end
      default: begin
        w_state_next = IDLE;
        w_timer_next = '0;
      end
    endcase
  end

  // State and timer registers.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state <= IDLE;
      r_timer <= '0;
    end else begin
      r_state <= w_state_next;
      r_timer <= w_timer_next;
    end
  end

  // Frame outputs: pulses every cycle, data/mask/count only on emit.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      frame_valid_out <= 1'b0;
      overrun_out     <= 1'b0;
      frame_data_out  <= '0;
      stale_mask_out  <= '0;
      frame_count_out <= '0;
    end else begin
      frame_valid_out <= w_emit;
      overrun_out     <= |w_overrun;
      if (w_emit) begin
        frame_data_out  <= w_emit_data;
        stale_mask_out  <= ~w_next_pending;
        frame_count_out <= frame_count_out + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_mic_frame_aligner.sv
// Randomized and directed bench for mic_frame_aligner against a frame-level
// reference model (start cycle + per-mic bookkeeping).
module tb_mic_frame_aligner;

  localparam int unsigned N  = 3;
  localparam int unsigned W  = 16;
  localparam int unsigned TO = 2048;

  logic           clk_in = 1'b0;
  logic           rst_in;
  logic [N-1:0]   mic_valid_in;
  logic [N*W-1:0] mic_data_in;
  logic           frame_valid_out;
  logic [N*W-1:0] frame_data_out;
  logic [N-1:0]   stale_mask_out;
  logic           overrun_out;
  logic [15:0]    frame_count_out;

  always #5 clk_in = ~clk_in;

  mic_frame_aligner #(
    .NUM_MICS      (N),
    .WIDTH         (W),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .mic_valid_in   (mic_valid_in),
    .mic_data_in    (mic_data_in),
    .frame_valid_out(frame_valid_out),
    .frame_data_out (frame_data_out),
    .stale_mask_out (stale_mask_out),
    .overrun_out    (overrun_out),
    .frame_count_out(frame_count_out)
  );

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model state.
  logic [N-1:0]   m_pend;
  logic [W-1:0]   m_hold [N];
  logic [W-1:0]   m_last [N];
  bit             m_active;
  longint         m_start;
  longint         m_cyc;
  logic           e_valid;
  logic           e_ov;
  logic [N*W-1:0] e_data;
  logic [N-1:0]   e_stale;
  logic [15:0]    e_count;

  // Directed-test observation.
  int steps;
  int mark;
  int pulses;
  int pulse_cyc;
  int ov_cyc;

  task automatic model_reset();
    m_pend = '0; m_active = 0; m_start = 0;
    for (int i = 0; i < N; i++) begin m_hold[i] = '0; m_last[i] = '0; end
    e_valid = 0; e_ov = 0; e_data = '0; e_stale = '0; e_count = '0;
  endtask

  task automatic model_step(input logic r, input logic [N-1:0] v, input logic [N*W-1:0] d);
    logic [N-1:0] np;
    logic [W-1:0] fld;
    bit           emit;
    if (r) begin
      model_reset();
    end else begin
      e_ov = |(v & m_pend);
      np   = m_pend | v;
      emit = (&np) || (m_active && (m_cyc - m_start == longint'(TO - 1)));
      e_valid = emit;
      if (emit) begin
        for (int i = 0; i < N; i++) begin
          fld = v[i] ? d[i*W +: W] : (m_pend[i] ? m_hold[i] : m_last[i]);
          e_data[i*W +: W] = fld;
          m_last[i] = fld;
        end
        e_stale  = ~np;
        e_count  = e_count + 16'd1;
        m_pend   = '0;
        m_active = 0;
      end else begin
        for (int i = 0; i < N; i++)
          if (v[i]) begin m_hold[i] = d[i*W +: W]; m_pend[i] = 1'b1; end
        if (!m_active && (|v)) begin m_active = 1; m_start = m_cyc; end
      end
    end
    m_cyc++;
  endtask

  task automatic step(input logic r, input logic [N-1:0] v, input logic [N*W-1:0] d);
    rst_in = r; mic_valid_in = v; mic_data_in = d;
    steps++;
    @(posedge clk_in);
    model_step(r, v, d);
    #1;
    check_eq("frame_valid", 64'(frame_valid_out), 64'(e_valid));
    check_eq("overrun",     64'(overrun_out),     64'(e_ov));
    check_eq("frame_data",  64'(frame_data_out),  64'(e_data));
    check_eq("stale_mask",  64'(stale_mask_out),  64'(e_stale));
    check_eq("frame_count", 64'(frame_count_out), 64'(e_count));
    if (frame_valid_out === 1'b1) begin pulses++; pulse_cyc = steps - mark; end
    if (overrun_out === 1'b1 && ov_cyc < 0) ov_cyc = steps - mark;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, '0, '0);
  endtask

  task automatic begin_test();
    mark = steps; pulses = 0; pulse_cyc = -1; ov_cyc = -1;
  endtask

  function automatic logic [N*W-1:0] pack3(input logic [W-1:0] a2, input logic [W-1:0] a1,
                                           input logic [W-1:0] a0);
    return {a2, a1, a0};
  endfunction

  initial begin
    logic [N*W-1:0] d;
    logic [N-1:0]   v;
    logic [W-1:0]   f;
    m_cyc = 0; steps = 0;
    model_reset();
    begin_test();

    // Reset state
    step(1'b1, '0, '0);
    step(1'b1, '0, '0);
    check_eq("reset_count", 64'(frame_count_out), 64'd0);

    // All mics on one edge
    begin_test();
    step(1'b0, 3'b111, pack3(16'h3333, 16'h2222, 16'h1111));
    idle(3);
    check_eq("t1_pulses", 64'(pulses), 64'd1);
    check_eq("t1_cycle",  64'(pulse_cyc), 64'd1);
    check_eq("t1_data",   64'(frame_data_out), 64'h3333_2222_1111);
    check_eq("t1_stale",  64'(stale_mask_out), 64'd0);
    check_eq("t1_count",  64'(frame_count_out), 64'd1);

    // Skewed arrivals
    begin_test();
    for (int c = 0; c < 46; c++) begin
      v = (c == 0) ? 3'b001 : (c == 10) ? 3'b010 : (c == 40) ? 3'b100 : 3'b000;
      step(1'b0, v, pack3(16'h0C00 + 16'(c), 16'h0B00 + 16'(c), 16'h0A00 + 16'(c)));
    end
    check_eq("t2_pulses", 64'(pulses), 64'd1);
    check_eq("t2_cycle",  64'(pulse_cyc), 64'd41);
    check_eq("t2_stale",  64'(stale_mask_out), 64'd0);

    // Timeout with mic2 silent, after a frame that carried mic2=0x0123
    step(1'b0, 3'b111, pack3(16'h0123, 16'h0456, 16'h0789));
    idle(2);
    begin_test();
    for (int c = 0; c < 2051; c++)
      step(1'b0, (c == 0) ? 3'b011 : 3'b000, pack3(16'h0, 16'h5151, 16'h5050));
    check_eq("t3_pulses", 64'(pulses), 64'd1);
    check_eq("t3_cycle",  64'(pulse_cyc), 64'd2048);
    d = frame_data_out;
    f = d[2*W +: W];
    check_eq("t3_mic2",   64'(f), 64'h0123);
    check_eq("t3_stale",  64'(stale_mask_out), 64'b100);

    // Mic2 arriving exactly on the timeout edge
    begin_test();
    for (int c = 0; c < 2051; c++)
      step(1'b0, (c == 0) ? 3'b011 : (c == 2047) ? 3'b100 : 3'b000,
           pack3((c == 2047) ? 16'h0456 : 16'h0, 16'h6161, 16'h6060));
    check_eq("t3b_cycle", 64'(pulse_cyc), 64'd2048);
    check_eq("t3b_stale", 64'(stale_mask_out), 64'd0);
    d = frame_data_out;
    f = d[2*W +: W];
    check_eq("t3b_mic2",  64'(f), 64'h0456);

    // Overrun on mic0
    begin_test();
    for (int c = 0; c < 25; c++) begin
      v = (c == 0 || c == 5) ? 3'b001 : (c == 20) ? 3'b110 : 3'b000;
      step(1'b0, v, pack3(16'h2C2C, 16'h1C1C, (c == 0) ? 16'h0AAA : 16'h0BBB));
    end
    check_eq("t4_ov_cycle", 64'(ov_cyc), 64'd6);
    check_eq("t4_cycle",    64'(pulse_cyc), 64'd21);
    d = frame_data_out;
    f = d[0 +: W];
    check_eq("t4_mic0",     64'(f), 64'h0BBB);

    // Reset mid-frame, then a lone mic2 times out
    begin_test();
    for (int c = 0; c < 31; c++)
      step((c == 30), (c == 0) ? 3'b011 : 3'b000, pack3(16'h0, 16'h7171, 16'h7070));
    idle(3);
    check_eq("t5_pulses", 64'(pulses), 64'd0);
    check_eq("t5_data0",  64'(frame_data_out), 64'd0);
    check_eq("t5_count0", 64'(frame_count_out), 64'd0);
    begin_test();
    for (int c = 0; c < 2051; c++)
      step(1'b0, (c == 0) ? 3'b100 : 3'b000, pack3(16'h0777, 16'h0, 16'h0));
    check_eq("t5_cycle", 64'(pulse_cyc), 64'd2048);
    check_eq("t5_stale", 64'(stale_mask_out), 64'b011);
    check_eq("t5_data",  64'(frame_data_out), 64'h0777_0000_0000);

    // Frame counter wrap with back-to-back frames
    step(1'b1, '0, '0);
    begin_test();
    for (int k = 1; k <= 65536; k++) begin
      step(1'b0, 3'b111, {16'($urandom), 16'($urandom), 16'($urandom)});
      if (k == 65535) check_eq("t6_count_ffff", 64'(frame_count_out), 64'hFFFF);
    end
    check_eq("t6_count_wrap", 64'(frame_count_out), 64'h0000);
    check_eq("t6_pulses",     64'(pulses), 64'd65536);

    // Randomized traffic with occasional reset
    step(1'b1, '0, '0);
    for (int k = 0; k < 4000; k++) begin
      for (int i = 0; i < N; i++) v[i] = ($urandom_range(0, 31) == 0);
      step(($urandom_range(0, 1499) == 0), v, {16'($urandom), 16'($urandom), 16'($urandom)});
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
